// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce/edge-detect front end.
// DEBOUNCE_EDGE_AR_GLITCH_CNT_EN (optional) adds an aborted-qualification counter.
package debounce_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } debounce_state_t;

  // Counter must hold 0..stable_cycles without wrapping
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_ar_if.sv
// Level/pulse bundle between the debouncer and its consumer.
// glitch_cnt exists only with DEBOUNCE_EDGE_AR_GLITCH_CNT_EN.
interface debounce_edge_ar_if
`ifdef DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
  #(parameter int unsigned GLITCH_W = 8)
`endif
  ();

  logic din;
  logic level;
  logic rise;
  logic fall;
  logic busy;
`ifdef DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_cnt;

  modport slave  (input din, output level, rise, fall, busy, glitch_cnt);
  modport master (output din, input level, rise, fall, busy, glitch_cnt);
`else
  modport slave  (input din, output level, rise, fall, busy);
  modport master (output din, input level, rise, fall, busy);
`endif

endinterface

// File: rtl/sync_chain_ar.sv
// Plain flop-chain synchroniser with async active-high reset to RST_VALUE.
module sync_chain_ar #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RST_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= {STAGES{RST_VALUE}};
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/debounce_edge_ar.sv
// Synchronise + debounce an async level, emit clean level and one-cycle rise/fall pulses.
// Optional DEBOUNCE_EDGE_AR_GLITCH_CNT_EN: saturating count of aborted qualifications.
module debounce_edge_ar
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned POR_VALUE     = 0,
  parameter int unsigned GLITCH_W      = 8
) (
  input logic              clk,
  input logic              rst,
  debounce_edge_ar_if.slave bus
);

  localparam int unsigned     CNT_W      = cnt_width(STABLE_CYCLES);
  localparam logic            POR_BIT    = POR_VALUE[0];
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam debounce_state_t POR_STATE  = POR_BIT ? STABLE_HI : STABLE_LO;

  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("STABLE_CYCLES must be >= 2");
  end
  if (GLITCH_W < 1) begin : g_bad_glitch
    $error("GLITCH_W must be >= 1");
  end

  logic ds;

  sync_chain_ar #(
    .STAGES   (SYNC_STAGES),
    .RST_VALUE(POR_BIT)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.din),
    .q  (ds)
  );

  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= POR_STATE;
      cnt_q   <= '0;
      level_q <= POR_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any sample equal to the current level during CHK_* aborts qualification
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (ds) begin
          state_d = CHK_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_HI: begin
        if (!ds) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!ds) begin
          state_d = CHK_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_LO: begin
        if (ds) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = POR_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.level = level_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.busy  = (state_q == CHK_HI) || (state_q == CHK_LO);

`ifdef DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q;
  logic                abort_c;

  assign abort_c = bus.busy && (ds == level_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          glitch_q <= '0;
    else if (abort_c && ~&glitch_q)   glitch_q <= glitch_q + GLITCH_W'(1);
  end

  assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_edge_ar.sv
// Directed bench for debounce_edge_ar (SYNC_STAGES=2, STABLE_CYCLES=4); two DUTs for POR 0 and 1.
module tb_debounce_edge_ar;

  logic clk;
  logic rst;
  int   total;
  int   bad;

`ifdef DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
  debounce_edge_ar_if #(.GLITCH_W(2)) bus_lo ();
  debounce_edge_ar_if #(.GLITCH_W(2)) bus_hi ();
`else
  debounce_edge_ar_if bus_lo ();
  debounce_edge_ar_if bus_hi ();
`endif

  debounce_edge_ar #(
    .SYNC_STAGES(2), .STABLE_CYCLES(4), .POR_VALUE(0), .GLITCH_W(2)
  ) dut_lo (
    .clk(clk), .rst(rst), .bus(bus_lo)
  );

  debounce_edge_ar #(
    .SYNC_STAGES(2), .STABLE_CYCLES(4), .POR_VALUE(1), .GLITCH_W(2)
  ) dut_hi (
    .clk(clk), .rst(rst), .bus(bus_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_lo.din = 1'b0;
    bus_hi.din = 1'b1;
    #3;
    total++;
    if (bus_lo.level !== 1'b0 || bus_lo.rise !== 1'b0 || bus_lo.fall !== 1'b0 || bus_lo.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_lo: level=%b rise=%b fall=%b busy=%b, want 0 0 0 0",
               bus_lo.level, bus_lo.rise, bus_lo.fall, bus_lo.busy);
    end
    total++;
    if (bus_hi.level !== 1'b1 || bus_hi.rise !== 1'b0 || bus_hi.fall !== 1'b0 || bus_hi.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hi: level=%b rise=%b fall=%b busy=%b, want 1 0 0 0",
               bus_hi.level, bus_hi.rise, bus_hi.fall, bus_hi.busy);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (bus_lo.level !== 1'b0 || bus_lo.busy !== 1'b0 || bus_lo.rise !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_lo[%0d]: level=%b busy=%b rise=%b, want 0 0 0",
                 i, bus_lo.level, bus_lo.busy, bus_lo.rise);
      end
      total++;
      if (bus_hi.level !== 1'b1 || bus_hi.fall !== 1'b0 || bus_hi.busy !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_hi[%0d]: level=%b fall=%b busy=%b, want 1 0 0",
                 i, bus_hi.level, bus_hi.fall, bus_hi.busy);
      end
    end
`ifdef DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
    total++;
    if (bus_lo.glitch_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_glitch: got %0d want 0", bus_lo.glitch_cnt);
    end
`endif
  endtask

  // Three high samples then low: the fourth (qualifying) sample mismatches
  task automatic test_bounce();
    for (int b = 1; b <= 5; b++) begin
      bus_lo.din = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        total++;
        if (bus_lo.rise !== 1'b0 || bus_lo.level !== 1'b0) begin
          bad++;
          $display("FAIL bounce%0d_hi[%0d]: rise=%b level=%b, want 0 0", b, i, bus_lo.rise, bus_lo.level);
        end
      end
      bus_lo.din = 1'b0;
      for (int i = 0; i < 7; i++) begin
        tick();
        total++;
        if (bus_lo.rise !== 1'b0 || bus_lo.level !== 1'b0) begin
          bad++;
          $display("FAIL bounce%0d_lo[%0d]: rise=%b level=%b, want 0 0", b, i, bus_lo.rise, bus_lo.level);
        end
      end
      total++;
      if (bus_lo.busy !== 1'b0) begin
        bad++;
        $display("FAIL bounce%0d_busy: got %b want 0", b, bus_lo.busy);
      end
`ifdef DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
      total++;
      if (bus_lo.glitch_cnt !== 2'((b < 3) ? b : 3)) begin
        bad++;
        $display("FAIL bounce%0d_glitch: got %0d want %0d", b, bus_lo.glitch_cnt, (b < 3) ? b : 3);
      end
`endif
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 20; i++) begin
      bus_lo.din = (i % 2 == 0);
      tick();
      total++;
      if (bus_lo.rise !== 1'b0 || bus_lo.level !== 1'b0) begin
        bad++;
        $display("FAIL toggle[%0d]: rise=%b level=%b, want 0 0", i, bus_lo.rise, bus_lo.level);
      end
    end
    bus_lo.din = 1'b0;
    repeat (6) tick();
    total++;
    if (bus_lo.busy !== 1'b0 || bus_lo.level !== 1'b0) begin
      bad++;
      $display("FAIL toggle_settle: busy=%b level=%b, want 0 0", bus_lo.busy, bus_lo.level);
    end
  endtask

  // After edge E+i, with din sampled high at E: busy for i=2..4, rise/level at i=5
  task automatic test_rise();
    bus_lo.din = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (bus_lo.busy !== (i >= 2 && i <= 4) || bus_lo.level !== (i >= 5) ||
          bus_lo.rise !== (i == 5) || bus_lo.fall !== 1'b0) begin
        bad++;
        $display("FAIL rise[%0d]: busy=%b level=%b rise=%b fall=%b, want %b %b %b 0", i,
                 bus_lo.busy, bus_lo.level, bus_lo.rise, bus_lo.fall,
                 (i >= 2 && i <= 4), (i >= 5), (i == 5));
      end
    end
  endtask

  task automatic test_fall();
    int falls;
    falls = 0;
    bus_lo.din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_lo.fall === 1'b1) falls++;
      total++;
      if (bus_lo.busy !== (i >= 2 && i <= 4) || bus_lo.level !== (i < 5) ||
          bus_lo.fall !== (i == 5) || bus_lo.rise !== 1'b0) begin
        bad++;
        $display("FAIL fall[%0d]: busy=%b level=%b fall=%b rise=%b, want %b %b %b 0", i,
                 bus_lo.busy, bus_lo.level, bus_lo.fall, bus_lo.rise,
                 (i >= 2 && i <= 4), (i < 5), (i == 5));
      end
    end
    total++;
    if (falls != 1) begin
      bad++;
      $display("FAIL fall_count: got %0d want 1", falls);
    end
  endtask

  task automatic test_reset_mid();
    bus_lo.din = 1'b1;
    repeat (4) tick();
    total++;
    if (bus_lo.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_busy: got %b want 1", bus_lo.busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus_lo.busy !== 1'b0 || bus_lo.level !== 1'b0 || bus_lo.rise !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: busy=%b level=%b rise=%b, want 0 0 0",
               bus_lo.busy, bus_lo.level, bus_lo.rise);
    end
    repeat (2) tick();
`ifdef DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
    total++;
    if (bus_lo.glitch_cnt !== 2'd0) begin
      bad++;
      $display("FAIL mid_glitch_clear: got %0d want 0", bus_lo.glitch_cnt);
    end
`endif
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (bus_lo.busy !== (k >= 3 && k <= 5) || bus_lo.level !== (k >= 6) || bus_lo.rise !== (k == 6)) begin
        bad++;
        $display("FAIL requal[%0d]: busy=%b level=%b rise=%b, want %b %b %b", k,
                 bus_lo.busy, bus_lo.level, bus_lo.rise, (k >= 3 && k <= 5), (k >= 6), (k == 6));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bounce();
    test_toggle();
    test_rise();
    test_fall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_edge_ar.md
Name: debounce_edge_ar

Overview:
Upstream conditioning stage for SR flip-flop style latches. It takes an asynchronous, bouncy level input (button, external status pin), synchronises it into the clk domain, and debounces it with a consecutive-sample counter. It emits a clean level plus single-cycle rise/fall pulses sized to drive the s/r inputs of the downstream set/reset register directly.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
STABLE_CYCLES, 4, consecutive stable synchronised samples required before accepting a new level; legal range >= 2.
POR_VALUE, 0, debounced level and synchroniser contents after reset; bit 0 used.
GLITCH_W, 8, width of the glitch counter; used only with the optional feature.

Ports:
clk  input  1  system clock; all state on posedge.
rst  input  1  asynchronous, active-high reset.
din  input  1  raw asynchronous level input.
level  output  1  debounced level.
rise  output  1  one-cycle pulse on an accepted 0->1 change.
fall  output  1  one-cycle pulse on an accepted 1->0 change.
busy  output  1  high while a candidate change is being qualified (CHK_* states).
glitch_cnt  output  GLITCH_W  aborted-qualification count; present only with DEBOUNCE_EDGE_AR_GLITCH_CNT_EN.

Behaviour:
- Reset (async assert, sync release by the system): sync chain = POR_VALUE[0]; level = POR_VALUE[0]; rise = fall = busy = 0; counter = 0; state = STABLE_HI if POR_VALUE[0] else STABLE_LO.
- Synchroniser: din shifts through SYNC_STAGES flops; ds = last stage. No logic between stages.
- Counter width: $clog2(STABLE_CYCLES+1). The counter counts consecutive cycles in which ds != level.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO: ds=1 -> CHK_HI, cnt=1.
  - CHK_HI: ds=1 and cnt==STABLE_CYCLES-1 -> STABLE_HI, level<=1, rise<=1, cnt<=0. ds=1 otherwise -> cnt++. ds=0 -> STABLE_LO, cnt<=0, glitch event.
  - STABLE_HI and CHK_LO mirror these transitions: level<=0, fall<=1.
- rise and fall are registered, high for exactly one cycle, and never high together. level changes on the same edge the pulse asserts.
- Latency: din stable from sampling edge E gives ds=new at edge E+SYNC_STAGES-1. level/rise then assert at edge E+SYNC_STAGES+STABLE_CYCLES-1, i.e. ds must be stable for STABLE_CYCLES samples.
- busy = (state==CHK_HI || state==CHK_LO), decoded from registered state.
- Boundary conditions:
  - A bounce shorter than STABLE_CYCLES samples produces no pulse and leaves level unchanged.
  - An input toggle on the qualifying edge counts as a mismatch and aborts qualification.
  - Continuous toggling every cycle never qualifies.
  - Reset during CHK_*: qualification is aborted, no pulse is issued, and the block returns to the POR state.
  - Counter never wraps; the maximum value reached is STABLE_CYCLES-1.

Optional Feature:
DEBOUNCE_EDGE_AR_GLITCH_CNT_EN
- Defined: glitch_cnt port exists. It resets to 0, increments on every CHK_*->STABLE_* abort, and saturates at all-ones with no wrap. A reset clears it.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package debounce_pkg:
  - state enum debounce_state_t {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO}, 2 bits.
  - Function cnt_width(stable_cycles) returning $clog2(stable_cycles+1).
  - Localparam MIN_SYNC_STAGES = 2.
- Sub-module sync_chain_ar (params STAGES, RST_VALUE; ports clk, rst, d, q): the synchroniser, reusable elsewhere. The main module holds the FSM and counter.

Test Plan:
- Reset with POR_VALUE=0, din=0: level=0, rise=fall=busy=0. Same with POR_VALUE=1: level=1, no fall pulse after reset release.
- SYNC_STAGES=2, STABLE_CYCLES=4; din 0->1 sampled at edge 10 and held: busy from edge 12, level=1 and rise=1 at edge 15 only; rise=0 at edge 16.
- Bounce: din high for 3 cycles then low (STABLE_CYCLES=4): no rise, level stays 0, busy returns to 0. With the macro, glitch_cnt = 1.
- Fall path: from level=1, din 1->0 held 10 cycles: exactly one fall pulse, and the latency matches the rise case.
- Reset asserted mid-CHK_HI at cnt=2: outputs return to POR immediately (asynchronously). After release with din still 1, full requalification occurs, giving rise 4 samples after ds=1.
- Macro on, GLITCH_W=2: 5 aborted bounces give glitch_cnt sequence 1,2,3,3,3 (saturation).
